// File: rtl/cpu_bus_arbiter.sv
// Two-master CPU bus arbiter (data cache = m0, instruction cache = m1).
// Round-robin on ties, grant held while the owner keeps requesting, bus watchdog with sticky fault.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; bus outputs 0; arbitrate pending requests
// ST_OWN   | owner's request/address/data routed to the bus; watchdog runs
// ST_ABORT | one-cycle forced completion (ready=1, rdata=all ones) after timeout
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_m0_rw,
  input  logic        i_m0_request,
  output logic        o_m0_ready,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_rw,
  input  logic        i_m1_request,
  output logic        o_m1_ready,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic        o_busy,
  output logic        o_fault,
  output logic [31:0] o_fault_address
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam bit          WDOG_EN    = (TIMEOUT != 0);
  localparam logic [15:0] WAIT_LIMIT = WDOG_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic        owner;
  logic        last;
  logic [15:0] wait_cnt;

  logic        owner_request;
  logic        owner_rw;
  logic [31:0] owner_address;
  logic [31:0] owner_wdata;
  logic        any_request;
  logic        grant_m1;

  assign owner_request = owner ? i_m1_request : i_m0_request;
  assign owner_rw      = owner ? i_m1_rw      : i_m0_rw;
  assign owner_address = owner ? i_m1_address : i_m0_address;
  assign owner_wdata   = owner ? i_m1_wdata   : i_m0_wdata;

  // m1 wins when it is the only requester, or on a tie when m0 was granted last.
  assign any_request = i_m0_request | i_m1_request;
  assign grant_m1    = i_m1_request & (~i_m0_request | ~last);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_IDLE;
      owner           <= 1'b0;
      last            <= 1'b1;
      wait_cnt        <= 16'd0;
      o_fault         <= 1'b0;
      o_fault_address <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= 16'd0;
          if (any_request) begin
            owner <= grant_m1;
            last  <= grant_m1;
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          // Ready and request-drop both take priority over the watchdog limit.
          if (!owner_request) begin
            state    <= ST_IDLE;
            wait_cnt <= 16'd0;
          end else if (i_bus_ready) begin
            wait_cnt <= 16'd0;
          end else if (WDOG_EN && (wait_cnt == WAIT_LIMIT)) begin
            state    <= ST_ABORT;
            wait_cnt <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_ABORT: begin
          o_fault         <= 1'b1;
          o_fault_address <= owner_address;
          wait_cnt        <= 16'd0;
          state           <= owner_request ? ST_OWN : ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    o_bus_rw      = 1'b0;
    o_bus_request = 1'b0;
    o_bus_address = 32'd0;
    o_bus_wdata   = 32'd0;
    o_m0_ready    = 1'b0;
    o_m0_rdata    = 32'd0;
    o_m1_ready    = 1'b0;
    o_m1_rdata    = 32'd0;
    case (state)
      ST_OWN: begin
        o_bus_rw      = owner_rw;
        o_bus_request = owner_request;
        o_bus_address = owner_address;
        o_bus_wdata   = owner_wdata;
        if (owner) begin
          o_m1_ready = i_bus_ready & owner_request;
          o_m1_rdata = i_bus_rdata;
        end else begin
          o_m0_ready = i_bus_ready & owner_request;
          o_m0_rdata = i_bus_rdata;
        end
      end
      ST_ABORT: begin
        if (owner) begin
          o_m1_ready = 1'b1;
          o_m1_rdata = 32'hFFFF_FFFF;
        end else begin
          o_m0_ready = 1'b1;
          o_m0_rdata = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed-vector bench for cpu_bus_arbiter: one instance with TIMEOUT=8, one with the watchdog off.
module tb_cpu_bus_arbiter;

  logic        i_clock, i_reset_n;
  logic        m0_rw, m0_req, m1_rw, m1_req, bus_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic        m0_ready, m1_ready, bus_rw, bus_req, busy, fault;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, fault_addr;

  logic        z_m0_ready, z_m1_ready, z_bus_rw, z_bus_req, z_busy, z_fault;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_bus_addr, z_bus_wdata, z_fault_addr;

  cpu_bus_arbiter #(.TIMEOUT(8)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_m0_rw(m0_rw), .i_m0_request(m0_req), .o_m0_ready(m0_ready),
    .i_m0_address(m0_addr), .i_m0_wdata(m0_wdata), .o_m0_rdata(m0_rdata),
    .i_m1_rw(m1_rw), .i_m1_request(m1_req), .o_m1_ready(m1_ready),
    .i_m1_address(m1_addr), .i_m1_wdata(m1_wdata), .o_m1_rdata(m1_rdata),
    .o_bus_rw(bus_rw), .o_bus_request(bus_req), .i_bus_ready(bus_ready),
    .o_bus_address(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata),
    .o_busy(busy), .o_fault(fault), .o_fault_address(fault_addr)
  );

  cpu_bus_arbiter #(.TIMEOUT(0)) dut_nowd (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_m0_rw(m0_rw), .i_m0_request(m0_req), .o_m0_ready(z_m0_ready),
    .i_m0_address(m0_addr), .i_m0_wdata(m0_wdata), .o_m0_rdata(z_m0_rdata),
    .i_m1_rw(m1_rw), .i_m1_request(m1_req), .o_m1_ready(z_m1_ready),
    .i_m1_address(m1_addr), .i_m1_wdata(m1_wdata), .o_m1_rdata(z_m1_rdata),
    .o_bus_rw(z_bus_rw), .o_bus_request(z_bus_req), .i_bus_ready(bus_ready),
    .o_bus_address(z_bus_addr), .o_bus_wdata(z_bus_wdata), .i_bus_rdata(bus_rdata),
    .o_busy(z_busy), .o_fault(z_fault), .o_fault_address(z_fault_addr)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic        m0_req, m0_rw;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_req, x_rw;
    logic [31:0] x_addr, x_wdata;
    logic        x_r0;
    logic [31:0] x_d0;
    logic        x_r1;
    logic [31:0] x_d1;
    logic        x_busy, x_fault;
    logic [31:0] x_faddr;
  } vec_t;

  localparam logic [31:0] M1_WDATA = 32'h0000_BEEF;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input int n,
                     input logic [31:0] r0, rw0, a0, wd0, r1, a1, rdy, rd,
                     input logic [31:0] xq, xrw, xa, xwd, xr0, xd0, xr1, xd1, xb, xf, xfa);
    vec_t v;
    v.m0_req = r0[0];  v.m0_rw = rw0[0]; v.m0_addr = a0; v.m0_wdata = wd0;
    v.m1_req = r1[0];  v.m1_addr = a1;   v.rdy = rdy[0]; v.rdata = rd;
    v.x_req = xq[0];   v.x_rw = xrw[0];  v.x_addr = xa;  v.x_wdata = xwd;
    v.x_r0 = xr0[0];   v.x_d0 = xd0;     v.x_r1 = xr1[0]; v.x_d1 = xd1;
    v.x_busy = xb[0];  v.x_fault = xf[0]; v.x_faddr = xfa;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, rw0, input logic [31:0] a0, wd0,
                       input logic r1, input logic [31:0] a1, input logic rdy, input logic [31:0] rd);
    m0_req = r0; m0_rw = rw0; m0_addr = a0; m0_wdata = wd0;
    m1_req = r1; m1_addr = a1; bus_ready = rdy; bus_rdata = rd;
  endtask

  initial begin
    logic bad;
    // ---- tie out of reset, then tie again while m0 was last ----
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 1,0,'h100,0, 1,'h200, 0,0,    0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 1,0,'h100,0, 1,'h200, 1,'hA1, 1,0,'h100,0, 1,'hA1,0,0, 1,0,0);
    add(1, 0,0,'h100,0, 1,'h200, 0,0,    0,0,'h100,0, 0,0,0,0, 1,0,0);
    add(1, 1,0,'h100,0, 1,'h200, 0,0,    0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 1,0,'h100,0, 1,'h200, 1,'hB2, 1,0,'h200,M1_WDATA, 0,0,1,'hB2, 1,0,0);
    add(1, 1,0,'h100,0, 0,'h200, 0,0,    0,0,'h200,M1_WDATA, 0,0,0,0, 1,0,0);
    add(1, 1,0,'h100,0, 0,'h200, 0,0,    0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 1,0,'h100,0, 0,'h200, 0,0,    1,0,'h100,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,'h100,0, 0,'h200, 0,0,    0,0,'h100,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    // ---- single m0 read, ready after 3 cycles ----
    add(1, 1,0,'h1000,0, 0,0, 0,0,       0,0,0,0, 0,0,0,0, 0,0,0);
    add(3, 1,0,'h1000,0, 0,0, 0,0,       1,0,'h1000,0, 0,0,0,0, 1,0,0);
    add(1, 1,0,'h1000,0, 0,0, 1,'h12345678, 1,0,'h1000,0, 1,'h12345678,0,0, 1,0,0);
    add(1, 0,0,'h1000,0, 0,0, 0,0,       0,0,'h1000,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    // ---- locked grant: write then read under one grant, m1 waiting ----
    add(1, 1,1,'h40,'hAAAA5555, 0,'h2000, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 1,1,'h40,'hAAAA5555, 1,'h2000, 1,0, 1,1,'h40,'hAAAA5555, 1,0,0,0, 1,0,0);
    add(1, 1,0,'h80,0, 1,'h2000, 0,0,    1,0,'h80,0, 0,0,0,0, 1,0,0);
    add(1, 1,0,'h80,0, 1,'h2000, 1,'hCAFEF00D, 1,0,'h80,0, 1,'hCAFEF00D,0,0, 1,0,0);
    add(1, 0,0,'h80,0, 1,'h2000, 0,0,    0,0,'h80,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,'h80,0, 1,'h2000, 0,0,    0,0,0,0, 0,0,0,0, 0,0,0);
    add(1, 0,0,'h80,0, 1,'h2000, 0,0,    1,0,'h2000,M1_WDATA, 0,0,0,0, 1,0,0);
    add(1, 0,0,'h80,0, 0,'h2000, 0,0,    0,0,'h2000,M1_WDATA, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    // ---- ready in the same cycle the watchdog would fire ----
    add(1, 1,0,'h3000,0, 0,0, 0,0,       0,0,0,0, 0,0,0,0, 0,0,0);
    add(7, 1,0,'h3000,0, 0,0, 0,0,       1,0,'h3000,0, 0,0,0,0, 1,0,0);
    add(1, 1,0,'h3000,0, 0,0, 1,'h55,    1,0,'h3000,0, 1,'h55,0,0, 1,0,0);
    add(1, 1,0,'h3000,0, 0,0, 0,0,       1,0,'h3000,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,'h3000,0, 0,0, 0,0,       0,0,'h3000,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    // ---- request drop in the same cycle as the watchdog limit ----
    add(1, 1,0,'h3004,0, 0,0, 0,0,       0,0,0,0, 0,0,0,0, 0,0,0);
    add(7, 1,0,'h3004,0, 0,0, 0,0,       1,0,'h3004,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,'h3004,0, 0,0, 0,0,       0,0,'h3004,0, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,0,0);
    // ---- timeout on m1, abort, then back to OWN while request stays high ----
    add(1, 0,0,0,0, 1,'h40000010, 0,0,   0,0,0,0, 0,0,0,0, 0,0,0);
    add(8, 0,0,0,0, 1,'h40000010, 0,0,   1,0,'h40000010,M1_WDATA, 0,0,0,0, 1,0,0);
    add(1, 0,0,0,0, 1,'h40000010, 0,'h12, 0,0,0,0, 0,0,1,'hFFFFFFFF, 1,0,0);
    add(1, 0,0,0,0, 1,'h40000010, 0,0,   1,0,'h40000010,M1_WDATA, 0,0,0,0, 1,1,'h40000010);
    add(1, 0,0,0,0, 0,'h40000010, 0,0,   0,0,'h40000010,M1_WDATA, 0,0,0,0, 1,1,'h40000010);
    add(1, 0,0,0,0, 0,0, 0,0,            0,0,0,0, 0,0,0,0, 0,1,'h40000010);

    m1_rw = 1'b0; m1_wdata = M1_WDATA;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge i_clock);
      drive(vecs[k].m0_req, vecs[k].m0_rw, vecs[k].m0_addr, vecs[k].m0_wdata,
            vecs[k].m1_req, vecs[k].m1_addr, vecs[k].rdy, vecs[k].rdata);
      #1;
      n_vec++;
      chk($sformatf("v%0d bus_request", k), 32'(bus_req), 32'(vecs[k].x_req));
      chk($sformatf("v%0d bus_rw", k), 32'(bus_rw), 32'(vecs[k].x_rw));
      chk($sformatf("v%0d bus_address", k), bus_addr, vecs[k].x_addr);
      chk($sformatf("v%0d bus_wdata", k), bus_wdata, vecs[k].x_wdata);
      chk($sformatf("v%0d m0_ready", k), 32'(m0_ready), 32'(vecs[k].x_r0));
      chk($sformatf("v%0d m0_rdata", k), m0_rdata, vecs[k].x_d0);
      chk($sformatf("v%0d m1_ready", k), 32'(m1_ready), 32'(vecs[k].x_r1));
      chk($sformatf("v%0d m1_rdata", k), m1_rdata, vecs[k].x_d1);
      chk($sformatf("v%0d busy", k), 32'(busy), 32'(vecs[k].x_busy));
      chk($sformatf("v%0d fault", k), 32'(fault), 32'(vecs[k].x_fault));
      chk($sformatf("v%0d fault_address", k), fault_addr, vecs[k].x_faddr);
    end

    // ---- asynchronous reset while m0 owns the bus ----
    @(negedge i_clock);
    drive(1, 0, 32'h7000, 0, 0, 32'h7100, 0, 0);
    @(negedge i_clock); #1;
    n_vec++;
    chk("rst pre bus_request", 32'(bus_req), 32'd1);
    chk("rst pre busy", 32'(busy), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    n_vec++;
    chk("rst async bus_request", 32'(bus_req), 32'd0);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async bus_address", bus_addr, 32'd0);
    chk("rst async fault", 32'(fault), 32'd0);
    chk("rst async fault_address", fault_addr, 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    drive(1, 0, 32'h7000, 0, 1, 32'h7100, 0, 0);
    @(negedge i_clock); #1;
    n_vec++;
    chk("rst tie bus_request", 32'(bus_req), 32'd1);
    chk("rst tie bus_address", bus_addr, 32'h7000);
    @(negedge i_clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge i_clock);

    // ---- watchdog disabled: 2000-cycle stall passes through untouched ----
    drive(1, 0, 32'h5000, 0, 0, 0, 0, 0);
    bad = 1'b0;
    repeat (2000) begin
      @(negedge i_clock); #1;
      if (z_bus_req !== 1'b1 || z_m0_ready !== 1'b0 || z_fault !== 1'b0 || z_busy !== 1'b1) bad = 1'b1;
    end
    n_vec++;
    chk("nowd stall held", 32'(bad), 32'd0);
    bus_ready = 1'b1; bus_rdata = 32'h600D_D00D;
    #1;
    n_vec++;
    chk("nowd m0_ready", 32'(z_m0_ready), 32'd1);
    chk("nowd m0_rdata", z_m0_rdata, 32'h600D_D00D);
    chk("nowd fault", 32'(z_fault), 32'd0);
    chk("nowd fault_address", z_fault_addr, 32'd0);
    @(negedge i_clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
